register_bus_datapath: RTL
==========================

REGISTER_BUS_DATAPATH -- requirements
Module: register_bus_datapath

Interface
REQ-001 Parameter DATA_W, default 8, width of every register, bus, memory address and memory data.
REQ-002 clock  in  1  rising-edge clock for all state.
REQ-003 reset  in  1  reset, asynchronous, active-high.
REQ-004 load_AR, load_PC, load_DR, load_AC, load_IR, load_TR  in  1 each  load the named register.
REQ-005 clear_AR, clear_PC, clear_DR, clear_AC, clear_TR  in  1 each  clear the named register to 0.
REQ-006 inc_AR, inc_PC, inc_DR, inc_AC, inc_TR  in  1 each  increment the named register.
REQ-007 memory_read, memory_write  in  1 each  memory access strobes.
REQ-008 bus_selectors  in  3  common-bus source select.
REQ-009 alu_enable  in  1  AC load source is ALU result, not bus.
REQ-010 alu_mode  in  3  ALU operation.
REQ-011 mem_rdata  in  DATA_W  combinational read data at mem_addr.
REQ-012 mem_addr  out  DATA_W  equals AR.
REQ-013 mem_wdata  out  DATA_W  equals common bus.
REQ-014 mem_we  out  1  synchronous write strobe to memory.
REQ-015 ir_out  out  8  IR contents; ac_out  out  DATA_W  AC contents.
REQ-016 carry, zero  out  1 each  registered ALU flags.
REQ-017 bus_conflict  out  1  sticky illegal-access flag.

Function
REQ-018 Bus mux (combinational): 000 zero, 001 AR, 010 PC, 011 DR, 100 AC, 101 {0, IR[3:0]}, 110 TR, 111 mem_rdata.
REQ-019 Per register each clock: clear > load > inc > hold; load takes bus value; inc wraps all-ones to 0.
REQ-020 IR has no clear/inc; load_IR captures bus[7:0].
REQ-021 AC with load_AC and alu_enable takes ALU result; with load_AC only, bus; alu_enable without load_AC has no effect on AC or flags.
REQ-022 ALU (A=AC, B=DR, DATA_W+1-bit internal): 000 A+B, 001 A-B (carry = no borrow), 010 A&B, 011 A|B, 100 A^B, 101 pass A, 110 ~A, 111 A<<1 (carry = A msb).
REQ-023 carry updates only on ALU loads of modes 000/001/111, else holds; zero updates on every AC write (ALU, bus, clear, inc) to reflect new AC == 0.
REQ-024 mem_we = memory_write && !(memory_read && bus_selectors == 111); write data is the bus in the same cycle.
REQ-025 memory_write && memory_read && bus_selectors == 111: write suppressed, bus_conflict set next edge, held until reset.
REQ-026 All register updates take effect one clock after control assertion; mem_addr reflects the new AR that same edge.
REQ-027 Simultaneous loads of several registers from one bus value all capture the same pre-edge bus value.

Reset
REQ-028 Reset asserted: AR, PC, DR, AC, IR, TR, carry, bus_conflict = 0; zero = 1; takes effect immediately, independent of clock.
REQ-029 Reset mid-cycle overrides any pending load/clear/inc; mem_we = 0 while reset is high.
REQ-030 First rising edge after reset release performs normal updates.

Structure
REQ-031 Shared package holds bus-select encodings (BUS_ZERO..BUS_MEM) and ALU mode encodings (ALU_ADD..ALU_SHL), shared with the control unit.
REQ-032 One sub-module, datapath_alu: combinational, inputs A, B, mode; outputs result and carry-out.
REQ-033 Six registers, bus mux, flag logic stay in the top module.

Verification
REQ-034 Reset, then bus_selectors=010, load_AR -> AR=0x00, mem_addr=0x00; inc_PC 3 cycles -> PC=0x03.
REQ-035 mem_rdata=0xA5, bus_selectors=111, load_IR -> ir_out=0xA5; bus_selectors=101, load_AR -> AR=0x05.
REQ-036 AC=0xF0, DR=0x20, alu_mode=000, alu_enable, load_AC -> AC=0x10, carry=1, zero=0; mode 001 with AC=DR=0x33 -> AC=0x00, carry=1, zero=1.
REQ-037 AC=0x5A, bus_selectors=100, memory_write, memory_read -> mem_we=1, mem_wdata=0x5A; same with bus_selectors=111 -> mem_we=0, bus_conflict=1 next edge.
REQ-038 clear_PC, load_PC, inc_PC same cycle with bus=0x44 -> PC=0x00; PC=0xFF, inc_PC -> PC=0x00.
REQ-039 load_AC with bus=0x77, reset pulsed between edges -> AC=0x00, zero=1 immediately, bus_conflict=0.

Source files
------------

// File: rtl/register_bus_datapath_pkg.sv
// Shared encodings for the register/bus datapath.
// Holds the common-bus source selects and the ALU operation codes. The
// control unit imports the same package, so both sides agree on encodings.
package register_bus_datapath_pkg;

  typedef enum logic [2:0] {
    BUS_ZERO = 3'b000,
    BUS_AR   = 3'b001,
    BUS_PC   = 3'b010,
    BUS_DR   = 3'b011,
    BUS_AC   = 3'b100,
    BUS_IR   = 3'b101,
    BUS_TR   = 3'b110,
    BUS_MEM  = 3'b111
  } bus_sel_e;

  typedef enum logic [2:0] {
    ALU_ADD  = 3'b000,
    ALU_SUB  = 3'b001,
    ALU_AND  = 3'b010,
    ALU_OR   = 3'b011,
    ALU_XOR  = 3'b100,
    ALU_PASS = 3'b101,
    ALU_NOT  = 3'b110,
    ALU_SHL  = 3'b111
  } alu_mode_e;

  // Instruction register width is fixed independent of DATA_W.
  localparam int IR_W = 8;

  // Only arithmetic and shift operations produce a meaningful carry.
  function automatic logic alu_sets_carry(input logic [2:0] mode);
    return (mode == ALU_ADD) || (mode == ALU_SUB) || (mode == ALU_SHL);
  endfunction

endpackage

// File: rtl/register_bus_datapath_alu.sv
// Combinational ALU for the register/bus datapath.
// Ports:
//   a, b       operands (a = AC, b = DR), DATA_W bits each
//   mode       operation select (alu_mode_e encoding)
//   result     DATA_W-bit result
//   carry_out  carry for add/shl, no-borrow for subtract, 0 otherwise
module datapath_alu
  import register_bus_datapath_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic [2:0]        mode,
  output logic [DATA_W-1:0] result,
  output logic              carry_out
);

  logic [DATA_W:0] wide;

  always_comb begin
    wide = '0;
    case (alu_mode_e'(mode))
      ALU_ADD:  wide = {1'b0, a} + {1'b0, b};
      // a + ~b + 1 leaves the top bit set exactly when no borrow occurs.
      ALU_SUB:  wide = {1'b0, a} + {1'b0, ~b} + (DATA_W + 1)'(1);
      ALU_AND:  wide = {1'b0, a & b};
      ALU_OR:   wide = {1'b0, a | b};
      ALU_XOR:  wide = {1'b0, a ^ b};
      ALU_PASS: wide = {1'b0, a};
      ALU_NOT:  wide = {1'b0, ~a};
      ALU_SHL:  wide = {a, 1'b0};
      default:  wide = '0;
    endcase
    result    = wide[DATA_W-1:0];
    carry_out = wide[DATA_W];
  end

endmodule

// File: rtl/register_bus_datapath.sv
// Register/bus datapath: six registers (AR, PC, DR, AC, IR, TR) sharing one
// common bus, an ALU feeding AC, carry/zero flags and a memory port.
// Ports:
//   clock, reset                 rising-edge clock, async active-high reset
//   load_*/clear_*/inc_*         per-register controls (clear > load > inc)
//   memory_read, memory_write    memory access strobes
//   bus_selectors                common-bus source (bus_sel_e)
//   alu_enable, alu_mode         AC loads from ALU instead of bus; ALU op
//   mem_rdata                    combinational read data at mem_addr
//   mem_addr, mem_wdata, mem_we  memory address (AR), write data (bus), strobe
//   ir_out, ac_out               IR and AC contents
//   carry, zero                  registered ALU flags
//   bus_conflict                 sticky flag for read+write with memory on bus
module register_bus_datapath
  import register_bus_datapath_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              load_AR,
  input  logic              load_PC,
  input  logic              load_DR,
  input  logic              load_AC,
  input  logic              load_IR,
  input  logic              load_TR,
  input  logic              clear_AR,
  input  logic              clear_PC,
  input  logic              clear_DR,
  input  logic              clear_AC,
  input  logic              clear_TR,
  input  logic              inc_AR,
  input  logic              inc_PC,
  input  logic              inc_DR,
  input  logic              inc_AC,
  input  logic              inc_TR,
  input  logic              memory_read,
  input  logic              memory_write,
  input  logic [2:0]        bus_selectors,
  input  logic              alu_enable,
  input  logic [2:0]        alu_mode,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [DATA_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_we,
  output logic [IR_W-1:0]   ir_out,
  output logic [DATA_W-1:0] ac_out,
  output logic              carry,
  output logic              zero,
  output logic              bus_conflict
);

  logic [DATA_W-1:0] ar, pc, dr, ac, tr;
  logic [IR_W-1:0]   ir;
  logic [DATA_W-1:0] bus;
  logic [DATA_W-1:0] alu_result;
  logic              alu_carry;
  logic [DATA_W-1:0] ac_next;
  logic              ac_write;
  logic              alu_load;
  logic              mem_on_bus_rw;

  // Shared priority for every clearable register: clear > load > inc > hold.
  // Increment wraps naturally at DATA_W bits.
  function automatic logic [DATA_W-1:0] next_reg(
    input logic [DATA_W-1:0] cur,
    input logic              clr,
    input logic              ld,
    input logic              inc,
    input logic [DATA_W-1:0] bus_val
  );
    if (clr)      return '0;
    else if (ld)  return bus_val;
    else if (inc) return cur + DATA_W'(1);
    else          return cur;
  endfunction

  datapath_alu #(.DATA_W(DATA_W)) u_alu (
    .a         (ac),
    .b         (dr),
    .mode      (alu_mode),
    .result    (alu_result),
    .carry_out (alu_carry)
  );

  always_comb begin
    bus = '0;
    case (bus_sel_e'(bus_selectors))
      BUS_ZERO: bus = '0;
      BUS_AR:   bus = ar;
      BUS_PC:   bus = pc;
      BUS_DR:   bus = dr;
      BUS_AC:   bus = ac;
      BUS_IR:   bus = DATA_W'(ir[3:0]);
      BUS_TR:   bus = tr;
      BUS_MEM:  bus = mem_rdata;
      default:  bus = '0;
    endcase
  end

  // Reading memory onto the bus while writing would write memory back to
  // itself; the write is dropped and the event is latched in bus_conflict.
  assign mem_on_bus_rw = memory_write && memory_read && (bus_selectors == BUS_MEM);

  assign mem_addr  = ar;
  assign mem_wdata = bus;
  assign mem_we    = memory_write && !(memory_read && (bus_selectors == BUS_MEM)) && !reset;
  assign ir_out    = ir;
  assign ac_out    = ac;

  // AC next value and whether AC is written this edge (drives zero flag).
  // alu_enable alone has no effect; it only steers the source of a load.
  always_comb begin
    alu_load = load_AC && alu_enable && !clear_AC;
    ac_write = clear_AC || load_AC || inc_AC;
    ac_next  = next_reg(ac, clear_AC, load_AC, inc_AC, bus);
    if (alu_load) ac_next = alu_result;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      ar           <= '0;
      pc           <= '0;
      dr           <= '0;
      ac           <= '0;
      ir           <= '0;
      tr           <= '0;
      carry        <= 1'b0;
      zero         <= 1'b1;
      bus_conflict <= 1'b0;
    end else begin
      ar <= next_reg(ar, clear_AR, load_AR, inc_AR, bus);
      pc <= next_reg(pc, clear_PC, load_PC, inc_PC, bus);
      dr <= next_reg(dr, clear_DR, load_DR, inc_DR, bus);
      tr <= next_reg(tr, clear_TR, load_TR, inc_TR, bus);
      ac <= ac_next;
      if (load_IR) ir <= IR_W'(bus);
      if (alu_load && alu_sets_carry(alu_mode)) carry <= alu_carry;
      if (ac_write) zero <= (ac_next == '0);
      if (mem_on_bus_rw) bus_conflict <= 1'b1;
    end
  end

endmodule
